// File: rtl/sc_playfield_scroller_pkg.sv
// sc_playfield_scroller_pkg: shared FSM encodings and widths for the road game
// (scroller, environment generator and display driver).
package sc_playfield_scroller_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_CRASH} state_t;
   localparam int ROW_W   = 8;
   localparam int LEVEL_W = 2;
   localparam int SCORE_W = 8;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
endpackage

// File: rtl/sc_playfield_scroller_if.sv
// sc_playfield_scroller_if: game-side bus of the playfield scroller.
//   START_InLow  start/restart request, active-low level
//   LEVEL_InBus  speed level 0..3
//   ROW_InBus    generated obstacle row, bit i = column i
//   CAR_InBus    player car column
//   ROW_TAKE_Out ROW_InBus consumed this cycle
//   MATRIX_OutBus field, row r at bits [8r+7:8r]
//   CRASH_Out    high while crashed
//   SCORE_OutBus rows scrolled this run, saturating
// master = game/generator side, slave = scroller.
interface sc_playfield_scroller_if
   import sc_playfield_scroller_pkg::*;
#(parameter int ROWS = 8);
   logic                    SC_PLAYFIELD_SCROLLER_START_InLow;
   logic [LEVEL_W-1:0]      SC_PLAYFIELD_SCROLLER_LEVEL_InBus;
   logic [ROW_W-1:0]        SC_PLAYFIELD_SCROLLER_ROW_InBus;
   logic [2:0]              SC_PLAYFIELD_SCROLLER_CAR_InBus;
   logic                    SC_PLAYFIELD_SCROLLER_ROW_TAKE_Out;
   logic [ROWS*ROW_W-1:0]   SC_PLAYFIELD_SCROLLER_MATRIX_OutBus;
   logic                    SC_PLAYFIELD_SCROLLER_CRASH_Out;
   logic [SCORE_W-1:0]      SC_PLAYFIELD_SCROLLER_SCORE_OutBus;
   modport master (
      output SC_PLAYFIELD_SCROLLER_START_InLow, SC_PLAYFIELD_SCROLLER_LEVEL_InBus,
             SC_PLAYFIELD_SCROLLER_ROW_InBus, SC_PLAYFIELD_SCROLLER_CAR_InBus,
      input  SC_PLAYFIELD_SCROLLER_ROW_TAKE_Out, SC_PLAYFIELD_SCROLLER_MATRIX_OutBus,
             SC_PLAYFIELD_SCROLLER_CRASH_Out, SC_PLAYFIELD_SCROLLER_SCORE_OutBus
   );
   modport slave (
      input  SC_PLAYFIELD_SCROLLER_START_InLow, SC_PLAYFIELD_SCROLLER_LEVEL_InBus,
             SC_PLAYFIELD_SCROLLER_ROW_InBus, SC_PLAYFIELD_SCROLLER_CAR_InBus,
      output SC_PLAYFIELD_SCROLLER_ROW_TAKE_Out, SC_PLAYFIELD_SCROLLER_MATRIX_OutBus,
             SC_PLAYFIELD_SCROLLER_CRASH_Out, SC_PLAYFIELD_SCROLLER_SCORE_OutBus
   );
endinterface

// File: rtl/sc_playfield_scroller_tick_divider.sv
// sc_tick_divider: scroll-rate divider, period = TICK_BASE >> level (min 1).
//   clk_i, rst_i  clock, async active-high reset
//   clr_i         force count to 0
//   en_i          count enable; count held at 0 while low
//   level_i       speed level, sampled every cycle
//   tick_o        terminal-count pulse (combinational on count/level)
module sc_tick_divider
   import sc_playfield_scroller_pkg::*;
#(parameter int TICK_BASE = 12_500_000) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic [LEVEL_W-1:0] level_i,
   output logic               tick_o
);
   localparam int CW = $clog2(TICK_BASE + 1);
   logic [CW-1:0] cnt_q, cnt_d, last;
   logic [31:0]   period;
   // A level change that leaves the count at or past the new terminal value
   // fires immediately instead of wrapping through the counter range.
   always_comb begin
      period = 32'(TICK_BASE) >> level_i;
      last   = period > 32'd1 ? CW'(period - 32'd1) : '0;
      tick_o = en_i && cnt_q >= last;
      cnt_d  = (clr_i || !en_i || tick_o) ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
endmodule

// File: rtl/sc_playfield_scroller.sv
// sc_playfield_scroller: ROWSx8 road playfield fed one generated row per scroll tick.
//   SC_PLAYFIELD_SCROLLER_CLOCK_50      50 MHz clock
//   SC_PLAYFIELD_SCROLLER_RESET_InHigh  async active-high reset
//   bus (slave)                         start/level/row/car in; take/matrix/crash/score out
// Build option: PLAYFIELD_INVINCIBLE_EN disables collision (never crashes).
module sc_playfield_scroller
   import sc_playfield_scroller_pkg::*;
#(
   parameter int ROWS      = 8,
   parameter int TICK_BASE = 12_500_000
) (
   input logic                    SC_PLAYFIELD_SCROLLER_CLOCK_50,
   input logic                    SC_PLAYFIELD_SCROLLER_RESET_InHigh,
   sc_playfield_scroller_if.slave bus
);
   state_t                      state_q, state_d;
   logic [ROWS-1:0][ROW_W-1:0]  mat_q, mat_d;
   logic [SCORE_W-1:0]          score_q, score_d;
   logic                        tick, hit, take, enter;
   sc_tick_divider #(.TICK_BASE(TICK_BASE)) u_div (
      .clk_i   (SC_PLAYFIELD_SCROLLER_CLOCK_50),
      .rst_i   (SC_PLAYFIELD_SCROLLER_RESET_InHigh),
      .clr_i   (enter),
      .en_i    (state_q == ST_RUN),
      .level_i (bus.SC_PLAYFIELD_SCROLLER_LEVEL_InBus),
      .tick_o  (tick)
   );
`ifdef PLAYFIELD_INVINCIBLE_EN
   assign hit = 1'b0;
`else
   // Checked every cycle so a sideways move into an obstacle also crashes.
   assign hit = state_q == ST_RUN && mat_q[ROWS-1][bus.SC_PLAYFIELD_SCROLLER_CAR_InBus];
`endif
   assign enter = state_q != ST_RUN && !bus.SC_PLAYFIELD_SCROLLER_START_InLow;
   // Collision wins over a coincident tick: the row is not consumed.
   assign take  = tick && !hit;
   always_comb begin
      state_d = state_q;
      mat_d   = mat_q;
      score_d = score_q;
      if (enter) begin
         state_d = ST_RUN;
         mat_d   = '0;
         score_d = '0;
      end else if (hit) begin
         state_d = ST_CRASH;
      end else if (take) begin
         mat_d   = {mat_q[ROWS-2:0], bus.SC_PLAYFIELD_SCROLLER_ROW_InBus};
         score_d = score_q == SCORE_MAX ? score_q : score_q + 1'b1;
      end
   end
   always_ff @(posedge SC_PLAYFIELD_SCROLLER_CLOCK_50 or posedge SC_PLAYFIELD_SCROLLER_RESET_InHigh)
      if (SC_PLAYFIELD_SCROLLER_RESET_InHigh) begin
         state_q <= ST_IDLE;
         mat_q   <= '0;
         score_q <= '0;
      end else begin
         state_q <= state_d;
         mat_q   <= mat_d;
         score_q <= score_d;
      end
   assign bus.SC_PLAYFIELD_SCROLLER_ROW_TAKE_Out  = take;
   assign bus.SC_PLAYFIELD_SCROLLER_MATRIX_OutBus = mat_q;
   assign bus.SC_PLAYFIELD_SCROLLER_CRASH_Out     = state_q == ST_CRASH;
   assign bus.SC_PLAYFIELD_SCROLLER_SCORE_OutBus  = score_q;
endmodule
